// File: rtl/prog_seq_pkg.sv
// Shared types for the program sequencer: next-PC operation codes returned
// by the datapath controller and the sequencer's top-level states.
package prog_seq_pkg;

  // Next-PC operation codes; codes 6 and 7 are reserved and treated as halt.
  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4,
    PC_HALT   = 3'd5
  } pc_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/prog_sequencer_ret_stack.sv
// Hardware return-address stack: a small LIFO of DEPTH entries, W bits each.
// Push is ignored when full and pop is ignored when empty; the caller is
// expected to check o_full/o_empty and raise its own error flags.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_wdata,
  output logic [W-1:0]     o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [LVL_W-1:0] r_level;
  logic [IDX_W-1:0] w_wrIdx;
  logic [IDX_W-1:0] w_topIdx;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_level == LVL_W'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign w_wrIdx  = IDX_W'(r_level);
  assign w_topIdx = IDX_W'(r_level - LVL_W'(1));

  // Entry storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[w_wrIdx] <= i_wdata;
    end
  end

  // Occupancy counter; push and pop never coincide, push wins if they did.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_level <= '0;
    end else if (w_doPush) begin
      r_level <= r_level + LVL_W'(1);
    end else if (w_doPop) begin
      r_level <= r_level - LVL_W'(1);
    end
  end

  // Top-of-stack view; reads as zero when nothing has been pushed.
  always_comb begin
    o_top = '0;
    if (!o_empty) begin
      o_top = r_mem[w_topIdx];
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: owns PC and IR, fetches over a req/ack handshake, then
// waits for the controller to finish and applies the returned next-PC op
// (sequential, relative branch, jump, call/return through ret_stack, halt).
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              INST_W      = 16,
  parameter int              OFF_W       = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic [PC_W-1:0]                    i_addr,
  output logic                               i_req,
  input  logic                               i_ack,
  input  logic [INST_W-1:0]                  i_data,
  output logic [INST_W-1:0]                  ir,
  output logic                               ir_valid,
  input  logic                               exec_done,
  input  logic [2:0]                         pc_op,
  input  logic                               branch_cond,
  input  logic [PC_W-1:0]                    pc_target,
  input  logic [OFF_W-1:0]                   pc_offset,
  output logic [PC_W-1:0]                    pc,
  output logic                               halted,
  output logic                               stack_ovf,
  output logic                               stack_unf,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  seq_state_t        r_state;
  seq_state_t        w_nextState;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_nextPc;
  logic [PC_W-1:0]   w_pcInst;
  logic [PC_W-1:0]   w_offExt;
  logic [PC_W-1:0]   w_stackTop;
  logic [INST_W-1:0] r_ir;
  logic              r_ovf;
  logic              r_unf;
  logic              w_setOvf;
  logic              w_setUnf;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_fetchDone;
  logic [LVL_W-1:0]  w_level;

  // pc already points past the instruction being executed, so branches are
  // taken relative to pc-1; the offset is sign-extended to full PC width.
  assign w_pcInst    = r_pc - PC_W'(1);
  assign w_offExt    = PC_W'($signed(pc_offset));
  assign w_fetchDone = (r_state == FETCH) && i_ack;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W),
    .LVL_W (LVL_W)
  ) u_retStack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (r_pc),
    .o_top   (w_stackTop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Next-state, next-PC and stack control for the fetch/execute cycle.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_setOvf    = 1'b0;
    w_setUnf    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        if (i_ack) begin
          w_nextState = EXEC;
          w_nextPc    = r_pc + PC_W'(1);
        end
      end
      EXEC: begin
        if (exec_done) begin
          w_nextState = FETCH;
          case (pc_op)
            PC_NEXT: begin
              w_nextPc = r_pc;
            end
            PC_BRANCH: begin
              if (branch_cond) begin
                w_nextPc = w_pcInst + w_offExt;
              end
            end
            PC_JUMP: begin
              w_nextPc = pc_target;
            end
            PC_CALL: begin
              if (w_full) begin
                w_setOvf    = 1'b1;
                w_nextState = HALT;
              end else begin
                w_push   = 1'b1;
                w_nextPc = pc_target;
              end
            end
            PC_RET: begin
              if (w_empty) begin
                w_setUnf    = 1'b1;
                w_nextState = HALT;
              end else begin
                w_pop    = 1'b1;
                w_nextPc = w_stackTop;
              end
            end
            default: begin
              w_nextState = HALT;
            end
          endcase
        end
      end
      HALT: begin
        w_nextState = HALT;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, PC and sticky error flags; reset beats any in-flight handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      if (w_setOvf) begin
        r_ovf <= 1'b1;
      end
      if (w_setUnf) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Instruction register captures read data on the completing fetch cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ir <= '0;
    end else if (w_fetchDone) begin
      r_ir <= i_data;
    end
  end

  assign i_req       = (r_state == FETCH);
  assign i_addr      = i_req ? r_pc : '0;
  assign ir          = r_ir;
  assign ir_valid    = (r_state == EXEC);
  assign halted      = (r_state == HALT);
  assign pc          = r_pc;
  assign stack_ovf   = r_ovf;
  assign stack_unf   = r_unf;
  assign stack_level = w_level;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios followed by a
// randomized instruction stream, all checked against a transaction-level
// model of PC, IR, return stack and error flags kept in this module.
module tb_prog_sequencer;

  localparam int PC_W  = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] i_addr;
  logic        i_req;
  logic        i_ack = 1'b0;
  logic [15:0] i_data = '0;
  logic [15:0] ir;
  logic        ir_valid;
  logic        exec_done = 1'b0;
  logic [2:0]  pc_op = '0;
  logic        branch_cond = 1'b0;
  logic [15:0] pc_target = '0;
  logic [7:0]  pc_offset = '0;
  logic [15:0] pc;
  logic        halted;
  logic        stack_ovf;
  logic        stack_unf;
  logic [2:0]  stack_level;

  int compCount = 0;
  int failCount = 0;

  logic [15:0] mPc;
  logic [15:0] mIr;
  logic [15:0] mStack[$];
  logic        mOvf;
  logic        mUnf;
  logic        mHalt;

  prog_sequencer #(
    .PC_W        (16),
    .INST_W      (16),
    .OFF_W       (8),
    .STACK_DEPTH (DEPTH),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .i_addr      (i_addr),
    .i_req       (i_req),
    .i_ack       (i_ack),
    .i_data      (i_data),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .exec_done   (exec_done),
    .pc_op       (pc_op),
    .branch_cond (branch_cond),
    .pc_target   (pc_target),
    .pc_offset   (pc_offset),
    .pc          (pc),
    .halted      (halted),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf),
    .stack_level (stack_level)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it, and on disagreement counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s check did not hold", tag);
    end
  endtask

  // Compare every architecturally visible output with the model.
  task automatic checkAll(input string tag, input logic expReq, input logic expValid);
    checkOutput({tag, "_pc"}, 32'(pc), 32'(mPc));
    checkOutput({tag, "_ir"}, 32'(ir), 32'(mIr));
    checkOutput({tag, "_irvalid"}, 32'(ir_valid), 32'(expValid));
    checkOutput({tag, "_req"}, 32'(i_req), 32'(expReq));
    checkOutput({tag, "_halted"}, 32'(halted), 32'(mHalt));
    checkOutput({tag, "_level"}, 32'(stack_level), 32'(mStack.size()));
    checkOutput({tag, "_ovf"}, 32'(stack_ovf), 32'(mOvf));
    checkOutput({tag, "_unf"}, 32'(stack_unf), 32'(mUnf));
    if (expReq) begin
      checkOutput({tag, "_addr"}, 32'(i_addr), 32'(mPc));
    end
  endtask

  // Hold reset low for two edges, then release and check the idle state.
  task automatic resetDut();
    rst = 1'b0; start = 1'b0; i_ack = 1'b0; exec_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mPc = 16'h0000; mIr = 16'h0000; mStack.delete();
    mOvf = 1'b0; mUnf = 1'b0; mHalt = 1'b0;
    checkAll("reset", 1'b0, 1'b0);
  endtask

  // Pulse start for one cycle; the sequencer should be requesting next.
  task automatic startDut();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_req", 32'(i_req), 32'h1);
    checkOutput("start_addr", 32'(i_addr), 32'(mPc));
  endtask

  // Complete one fetch after `lat` cycles of i_ack low.
  task automatic fetchInstr(input logic [15:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      i_ack = 1'b0;
      checkOutput("wait_req", 32'(i_req), 32'h1);
      checkOutput("wait_addr", 32'(i_addr), 32'(mPc));
      @(negedge clk);
    end
    checkOutput("ack_addr", 32'(i_addr), 32'(mPc));
    i_ack  = 1'b1;
    i_data = data;
    @(negedge clk);
    i_ack  = 1'b0;
    i_data = 16'($urandom);
    mIr = data;
    mPc = 16'((int'(mPc) + 1) % 65536);
    checkAll("fetch", 1'b0, 1'b1);
  endtask

  // Reference behaviour of one completed instruction.
  task automatic modelExec(input logic [2:0] op, input logic cond,
                           input logic [15:0] target, input logic [7:0] offset);
    int pcInst;
    int off;
    pcInst = (int'(mPc) + 65535) % 65536;
    off    = (offset >= 8'd128) ? int'(offset) - 256 : int'(offset);
    case (op)
      3'd0: ;
      3'd1: if (cond) mPc = 16'((pcInst + off + 65536) % 65536);
      3'd2: mPc = target;
      3'd3: begin
        if (mStack.size() < DEPTH) begin
          mStack.push_back(mPc);
          mPc = target;
        end else begin
          mOvf = 1'b1;
          mHalt = 1'b1;
        end
      end
      3'd4: begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin
          mUnf = 1'b1;
          mHalt = 1'b1;
        end
      end
      default: mHalt = 1'b1;
    endcase
  endtask

  // Hold EXEC for `wt` cycles, then complete it with the given operation.
  task automatic applyStimulus(input logic [2:0] op, input logic cond,
                               input logic [15:0] target, input logic [7:0] offset,
                               input int wt);
    for (int i = 0; i < wt; i++) begin
      exec_done = 1'b0;
      pc_op = 3'($urandom);
      checkOutput("exec_hold", 32'(ir_valid), 32'h1);
      @(negedge clk);
    end
    exec_done   = 1'b1;
    pc_op       = op;
    branch_cond = cond;
    pc_target   = target;
    pc_offset   = offset;
    @(negedge clk);
    exec_done   = 1'b0;
    pc_target   = 16'($urandom);
    pc_offset   = 8'($urandom);
    modelExec(op, cond, target, offset);
    checkAll("exec", !mHalt, 1'b0);
  endtask

  // Directed scenarios, then a randomized instruction stream.
  initial begin
    int r;
    logic [2:0] op;
    $display("[TB] prog_sequencer bench starting");

    // First fetch with a three-cycle request window.
    resetDut();
    startDut();
    fetchInstr(16'hA5C3, 2);
    checkOutput("first_ir", 32'(ir), 32'h0000A5C3);
    checkOutput("first_pc", 32'(pc), 32'h00000001);

    // Taken backward branch from 0x0010 by -4.
    applyStimulus(3'd2, 1'b0, 16'h0010, 8'h00, 1);
    fetchInstr(16'h1111, 0);
    applyStimulus(3'd1, 1'b1, 16'h0000, 8'hFC, 0);
    checkOutput("br_taken_addr", 32'(i_addr), 32'h0000000C);

    // Not-taken branch from 0x0010.
    fetchInstr(16'h2222, 1);
    applyStimulus(3'd2, 1'b0, 16'h0010, 8'h00, 0);
    fetchInstr(16'h3333, 0);
    applyStimulus(3'd1, 1'b0, 16'h0000, 8'hFC, 2);
    checkOutput("br_nottaken_addr", 32'(i_addr), 32'h00000011);

    // Call to 0x0100 from 0x0020, then return.
    fetchInstr(16'h4444, 0);
    applyStimulus(3'd2, 1'b0, 16'h0020, 8'h00, 0);
    fetchInstr(16'h5555, 0);
    applyStimulus(3'd3, 1'b0, 16'h0100, 8'h00, 0);
    checkOutput("call_addr", 32'(i_addr), 32'h00000100);
    checkOutput("call_level", 32'(stack_level), 32'h1);
    fetchInstr(16'h6666, 0);
    applyStimulus(3'd4, 1'b0, 16'h0000, 8'h00, 1);
    checkOutput("ret_addr", 32'(i_addr), 32'h00000021);
    checkOutput("ret_level", 32'(stack_level), 32'h0);

    // PC wrap from 0xFFFF.
    fetchInstr(16'h7777, 0);
    applyStimulus(3'd2, 1'b0, 16'hFFFF, 8'h00, 0);
    fetchInstr(16'h8888, 0);
    checkOutput("wrap_pc", 32'(pc), 32'h0);
    applyStimulus(3'd0, 1'b0, 16'h1234, 8'h00, 0);
    checkOutput("wrap_addr", 32'(i_addr), 32'h0);

    // Five nested calls on a four-deep stack.
    for (int k = 0; k < 5; k++) begin
      fetchInstr(16'(16'h9000 + k), 0);
      applyStimulus(3'd3, 1'b0, 16'(16'h0200 + 16 * k), 8'h00, 0);
    end
    checkOutput("ovf_flag", 32'(stack_ovf), 32'h1);
    checkOutput("ovf_halted", 32'(halted), 32'h1);
    checkOutput("ovf_pc", 32'(pc), 32'h00000231);

    // Start is ignored while halted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkAll("halt_hold", 1'b0, 1'b0);

    // Return with an empty stack.
    resetDut();
    startDut();
    fetchInstr(16'hABCD, 0);
    applyStimulus(3'd4, 1'b0, 16'h0000, 8'h00, 0);
    checkOutput("unf_flag", 32'(stack_unf), 32'h1);
    checkOutput("unf_halted", 32'(halted), 32'h1);

    // Reset during a fetch, with a late ack in the reset cycle.
    resetDut();
    startDut();
    fetchInstr(16'hBEEF, 0);
    applyStimulus(3'd0, 1'b0, 16'h0000, 8'h00, 0);
    rst = 1'b0;
    i_ack = 1'b1;
    i_data = 16'hDEAD;
    @(negedge clk);
    rst = 1'b1;
    i_ack = 1'b0;
    mPc = 16'h0000; mIr = 16'h0000; mStack.delete();
    mOvf = 1'b0; mUnf = 1'b0; mHalt = 1'b0;
    checkAll("rst_fetch", 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkAll("rst_idle", 1'b0, 1'b0);

    // Randomized instruction stream.
    startDut();
    for (int n = 0; n < 150; n++) begin
      if (mHalt) begin
        resetDut();
        startDut();
      end
      fetchInstr(16'($urandom), $urandom_range(0, 3));
      r = $urandom_range(0, 15);
      if (r < 5)       op = 3'd0;
      else if (r < 8)  op = 3'd1;
      else if (r < 10) op = 3'd2;
      else if (r < 13) op = 3'd3;
      else if (r < 15) op = 3'd4;
      else             op = 3'($urandom_range(5, 7));
      applyStimulus(op, 1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
